// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 16x oversample constants
// and the parity helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_e;

  localparam logic [3:0] OS_MID_SAMPLE = 4'd7;
  localparam logic [3:0] OS_WRAP       = 4'd15;

  // Value the parity bit must carry for this data: odd=1 selects odd parity.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return odd ^ (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect. The edge
// detector stays disarmed until the synchronizer has seen the real line high.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic rx_fall_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [1:0] flush_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      flush_q <= 2'b00;
      prev_q  <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      flush_q <= {flush_q[0], 1'b1};
      // A line already low when reset drops must first return high to arm.
      prev_q  <= sync_q & flush_q[1];
    end
  end

  assign rx_sync_o = sync_q;
  assign rx_fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_async.sv
// 16x-oversampled UART receiver with 7/8-bit data, optional parity, sticky
// error flags and either a single holding register or an external FIFO port.
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int RX_FIFO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_x16_pulse,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_errors,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic [7:0] rx_dout,
  output logic       rx_rdy,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       fifo_write_rx
);

  uart_rx_state_e state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     data_q, data_d;

  logic [7:0]     rx_dout_q, rx_dout_d;
  logic           rx_rdy_q, rx_rdy_d;
  logic           parity_err_q, parity_err_d;
  logic           framing_err_q, framing_err_d;
  logic           overflow_q, overflow_d;
  logic           fifo_wr_n_q, fifo_wr_n_d;

  logic           rx_s;
  logic           rx_fall;
  logic           sample_wrap;
  logic           frame_done;
  logic           parity_set;
  logic           framing_set;
  logic           overflow_set;

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx_i      (rx),
    .rx_sync_o (rx_s),
    .rx_fall_o (rx_fall)
  );

  assign sample_wrap = baud_x16_pulse && (cnt_q == OS_WRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    frame_done  = 1'b0;
    parity_set  = 1'b0;
    framing_set = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = RX_START;
      end
      RX_START: begin
        if (baud_x16_pulse) begin
          if (cnt_q == OS_MID_SAMPLE) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d   = RX_DATA;
              bit_cnt_d = '0;
              data_d    = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (baud_x16_pulse) cnt_d = cnt_q + 4'd1;
        if (sample_wrap) begin
          data_d[bit_cnt_q] = rx_s;
          bit_cnt_d         = bit_cnt_q + 3'd1;
          if (bit_cnt_q == (bit8 ? 3'd7 : 3'd6))
            state_d = parity_en ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (baud_x16_pulse) cnt_d = cnt_q + 4'd1;
        if (sample_wrap) begin
          parity_set = (rx_s != parity_bit(data_q, odd_n_even));
          state_d    = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_x16_pulse) cnt_d = cnt_q + 4'd1;
        if (sample_wrap) begin
          framing_set = !rx_s;
          frame_done  = 1'b1;
          state_d     = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_dout_d    = rx_dout_q;
    rx_rdy_d     = rx_rdy_q;
    fifo_wr_n_d  = 1'b1;
    overflow_set = 1'b0;

    if (RX_FIFO != 0) begin
      rx_rdy_d = !fifo_empty;
      if (frame_done) begin
        if (!fifo_full) begin
          rx_dout_d   = data_q;
          fifo_wr_n_d = 1'b0;
        end else begin
          overflow_set = 1'b1;
        end
      end
    end else begin
      if (read_rx_byte) rx_rdy_d = 1'b0;
      // A read in the completion cycle frees the holding register in time.
      if (frame_done) begin
        if (!rx_rdy_q || read_rx_byte) begin
          rx_dout_d = data_q;
          rx_rdy_d  = 1'b1;
        end else begin
          overflow_set = 1'b1;
        end
      end
    end

    parity_err_d  = parity_set   | (parity_err_q  & ~clear_errors);
    framing_err_d = framing_set  | (framing_err_q & ~clear_errors);
    overflow_d    = overflow_set | (overflow_q    & ~clear_errors);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_dout_q     <= '0;
      rx_rdy_q      <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      fifo_wr_n_q   <= 1'b1;
    end else begin
      rx_dout_q     <= rx_dout_d;
      rx_rdy_q      <= rx_rdy_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
      fifo_wr_n_q   <= fifo_wr_n_d;
    end
  end

  assign rx_dout       = rx_dout_q;
  assign rx_rdy        = rx_rdy_q;
  assign parity_err    = parity_err_q;
  assign framing_err   = framing_err_q;
  assign overflow      = overflow_q;
  assign fifo_write_rx = fifo_wr_n_q;

endmodule

// File: tb/tb_uart_rx_async.sv
// Self-checking bench for uart_rx_async: a holding-register instance checked
// through a scoreboard, plus an external-FIFO instance sharing the same line.
module tb_uart_rx_async;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_x16_pulse = 1'b0;
  logic       rx = 1'b0;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       read_rx_byte = 1'b0;
  logic       clear_errors = 1'b0;
  logic       fifo_full = 1'b0;
  logic       fifo_empty = 1'b1;

  logic [7:0] rx_dout0, rx_dout1;
  logic       rx_rdy0, rx_rdy1;
  logic       pe0, pe1, fe0, fe1, ovf0, ovf1, wr0, wr1;

  uart_rx_async #(.RX_FIFO(0)) dut0 (
    .clk(clk), .reset(reset), .baud_x16_pulse(baud_x16_pulse), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_errors(clear_errors),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rx_dout(rx_dout0), .rx_rdy(rx_rdy0), .parity_err(pe0),
    .framing_err(fe0), .overflow(ovf0), .fifo_write_rx(wr0)
  );

  uart_rx_async #(.RX_FIFO(1)) dut1 (
    .clk(clk), .reset(reset), .baud_x16_pulse(baud_x16_pulse), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .clear_errors(clear_errors),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .rx_dout(rx_dout1), .rx_rdy(rx_rdy1), .parity_err(pe1),
    .framing_err(fe1), .overflow(ovf1), .fifo_write_rx(wr1)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic       rdy;
    logic       pe;
    logic       fe;
    logic       ovf;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  logic [7:0] wr_data = '0;

  // Reference model of the holding-register receiver's visible state.
  logic [7:0] m_dout = '0;
  logic       m_rdy = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_ovf = 1'b0;

  always #5 clk = ~clk;

  // 16x strobe every fourth clock: one bit time is 64 clocks.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    baud_x16_pulse = (cyc % 4 == 0);
  end

  always @(negedge clk) begin
    if (!wr1) begin
      wr_cnt++;
      wr_data = rx_dout1;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame, model its effect, and compare once the line is idle again.
  task automatic send_frame(input logic [7:0] data, input bit b8, input bit pen,
                            input bit par_flip, input bit stop_bit,
                            input bit chk_timing, input bit rd_at_done);
    logic [7:0] masked;
    logic       pbit;
    int         nb;
    int         target;
    exp_t       e;

    masked    = b8 ? data : {1'b0, data[6:0]};
    nb        = b8 ? 8 : 7;
    pbit      = odd_n_even ^ (^masked) ^ par_flip;
    bit8      = b8;
    parity_en = pen;
    target    = 8 + 16 * (nb + (pen ? 1 : 0) + 1);

    if (!m_rdy || rd_at_done) begin
      m_dout = masked;
      m_rdy  = 1'b1;
    end else begin
      m_ovf = 1'b1;
    end
    if (pen && par_flip) m_pe = 1'b1;
    if (!stop_bit) m_fe = 1'b1;
    e.dout = m_dout; e.rdy = m_rdy; e.pe = m_pe; e.fe = m_fe; e.ovf = m_ovf;
    sb_q.push_back(e);

    fork
      begin
        rx = 1'b0;
        hold(64);
        for (int i = 0; i < nb; i++) begin
          rx = masked[i];
          hold(64);
        end
        if (pen) begin
          rx = pbit;
          hold(64);
        end
        rx = stop_bit;
        hold(64);
        rx = 1'b1;
      end
      begin
        int   n;
        logic prev_rdy;
        n = 0;
        prev_rdy = 1'b0;
        repeat (3) @(posedge clk);
        while (n < target) begin
          prev_rdy = rx_rdy0;
          @(posedge clk);
          if (baud_x16_pulse) n++;
          #2;
          read_rx_byte = rd_at_done && (n == target - 1) && baud_x16_pulse;
        end
        read_rx_byte = 1'b0;
        if (chk_timing) begin
          check("rdy_before_stop_sample", prev_rdy, 1'b0);
          check("rdy_after_stop_sample", rx_rdy0, 1'b1);
        end
      end
    join

    hold(4);
    e = sb_q.pop_front();
    check("rx_dout", rx_dout0, e.dout);
    check("rx_rdy", rx_rdy0, e.rdy);
    check("parity_err", pe0, e.pe);
    check("framing_err", fe0, e.fe);
    check("overflow", ovf0, e.ovf);
  endtask

  task automatic read_byte();
    read_rx_byte = 1'b1;
    hold(1);
    read_rx_byte = 1'b0;
    m_rdy = 1'b0;
    check("rdy_after_read", rx_rdy0, m_rdy);
  endtask

  task automatic clear_errs();
    clear_errors = 1'b1;
    hold(1);
    clear_errors = 1'b0;
    m_pe = 1'b0; m_fe = 1'b0; m_ovf = 1'b0;
    check("pe_after_clear", pe0, m_pe);
    check("fe_after_clear", fe0, m_fe);
    check("ovf_after_clear", ovf0, m_ovf);
  endtask

  initial begin
    hold(3);
    check("reset_dout", rx_dout0, 8'h00);
    check("reset_rdy", rx_rdy0, 1'b0);
    check("reset_pe", pe0, 1'b0);
    check("reset_fe", fe0, 1'b0);
    check("reset_ovf", ovf0, 1'b0);
    check("reset_wr", wr0, 1'b1);
    check("reset_wr_fifo", wr1, 1'b1);

    // Line held low through reset release must not start a frame.
    reset = 1'b0;
    hold(800);
    check("low_at_release_rdy", rx_rdy0, 1'b0);
    check("low_at_release_fe", fe0, 1'b0);
    rx = 1'b1;
    hold(100);

    // 8N1 0xA5 with completion timing.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    read_byte();

    // 7-bit even parity 0x41 with a wrong parity bit.
    odd_n_even = 1'b0;
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    clear_errs();
    read_byte();

    // 8-bit odd parity, correct parity bit.
    odd_n_even = 1'b1;
    send_frame(8'hF1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    read_byte();
    odd_n_even = 1'b0;

    // Stop bit driven low.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_errs();
    read_byte();

    // Overflow, then a read coincident with completion.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clear_errs();
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    read_byte();

    // Four-sample glitch is a false start.
    rx = 1'b0;
    hold(16);
    rx = 1'b1;
    hold(200);
    check("glitch_rdy", rx_rdy0, 1'b0);
    check("glitch_fe", fe0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    read_byte();

    // External FIFO instance: one write pulse when not full.
    fifo_full = 1'b0;
    wr_cnt = 0;
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fifo_write_count", wr_cnt, 1);
    check("fifo_write_data", wr_data, 8'hC3);
    check("fifo_no_ovf", ovf1, 1'b0);
    read_byte();

    // Full FIFO: no write, overflow instead.
    fifo_full = 1'b1;
    wr_cnt = 0;
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fifo_full_write_count", wr_cnt, 0);
    check("fifo_full_ovf", ovf1, 1'b1);
    fifo_empty = 1'b0;
    hold(2);
    check("fifo_rdy_not_empty", rx_rdy1, 1'b1);
    fifo_empty = 1'b1;
    hold(2);
    check("fifo_rdy_empty", rx_rdy1, 1'b0);
    read_byte();
    clear_errs();

    // Load visible state, then reset in the middle of a data bit.
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    hold(104);
    rx = 1'b1;
    hold(20);
    #3;
    reset = 1'b1;
    #1;
    check("midframe_reset_dout", rx_dout0, 8'h00);
    check("midframe_reset_rdy", rx_rdy0, 1'b0);
    check("midframe_reset_pe", pe0, 1'b0);
    check("midframe_reset_fe", fe0, 1'b0);
    check("midframe_reset_ovf", ovf0, 1'b0);
    check("midframe_reset_wr", wr0, 1'b1);
    check("midframe_reset_fifo_ovf", ovf1, 1'b0);
    check("midframe_reset_fifo_dout", rx_dout1, 8'h00);
    hold(3);
    reset = 1'b0;
    m_dout = '0; m_rdy = 1'b0; m_pe = 1'b0; m_fe = 1'b0; m_ovf = 1'b0;
    hold(50);

    // Receiver resumes normally after reset.
    send_frame(8'h3F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
